pu_or1k_bus_arbiter: RTL

PU_OR1K_BUS_ARBITER -- requirements
Module: pu_or1k_bus_arbiter

---
 rtl/pu_or1k_pkg.sv | 17 +
 rtl/pu_or1k_bus_arbiter_if.sv | 54 +++++
 rtl/pu_or1k_bus_watchdog.sv | 34 +++
 rtl/pu_or1k_bus_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pu_or1k_pkg.sv
// pu_or1k_pkg -- shared types and constants for the OR1K bus arbiter slice.
//   arb_state_e : arbiter FSM states (idle, ibus granted, dbus granted)
//   port_id_t   : identifies a CPU-side port; PORT_I / PORT_D constants
package pu_or1k_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_I = 1'b0;
    localparam port_id_t PORT_D = 1'b1;

endpackage

// File: rtl/pu_or1k_bus_arbiter_if.sv
// pu_or1k_bus_arbiter_if -- signal bundle between the two CPU ports
// (instruction fetch, load/store), the arbiter and the shared Wishbone side.
//   ibus_* : fetch port (req/adr/burst in, ack/err/dat out)
//   dbus_* : load/store port (req/adr/dat/bsel/we/burst in, ack/err/dat out)
//   bus_*  : shared bus (req/we/burst/adr/dat/bsel out, ack/err/dat in)
// Modports: slave = arbiter view, master = the surrounding CPU/bus view.
interface pu_or1k_bus_arbiter_if;

    logic        ibus_req_i;
    logic [31:0] ibus_adr_i;
    logic        ibus_burst_i;
    logic        ibus_ack_o;
    logic        ibus_err_o;
    logic [31:0] ibus_dat_o;

    logic        dbus_req_i;
    logic [31:0] dbus_adr_i;
    logic [31:0] dbus_dat_i;
    logic [3:0]  dbus_bsel_i;
    logic        dbus_we_i;
    logic        dbus_burst_i;
    logic        dbus_ack_o;
    logic        dbus_err_o;
    logic [31:0] dbus_dat_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic        bus_burst_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_o;
    logic [3:0]  bus_bsel_o;
    logic        bus_ack_i;
    logic        bus_err_i;
    logic [31:0] bus_dat_i;

    modport slave (
        input  ibus_req_i, ibus_adr_i, ibus_burst_i,
        output ibus_ack_o, ibus_err_o, ibus_dat_o,
        input  dbus_req_i, dbus_adr_i, dbus_dat_i, dbus_bsel_i, dbus_we_i, dbus_burst_i,
        output dbus_ack_o, dbus_err_o, dbus_dat_o,
        output bus_req_o, bus_we_o, bus_burst_o, bus_adr_o, bus_dat_o, bus_bsel_o,
        input  bus_ack_i, bus_err_i, bus_dat_i
    );

    modport master (
        output ibus_req_i, ibus_adr_i, ibus_burst_i,
        input  ibus_ack_o, ibus_err_o, ibus_dat_o,
        output dbus_req_i, dbus_adr_i, dbus_dat_i, dbus_bsel_i, dbus_we_i, dbus_burst_i,
        input  dbus_ack_o, dbus_err_o, dbus_dat_o,
        input  bus_req_o, bus_we_o, bus_burst_o, bus_adr_o, bus_dat_o, bus_bsel_o,
        output bus_ack_i, bus_err_i, bus_dat_i
    );

endinterface

// File: rtl/pu_or1k_bus_watchdog.sv
// pu_or1k_bus_watchdog -- no-response watchdog for a granted bus cycle.
//   clk, rst : clock, synchronous active-high reset
//   active   : a port currently holds the grant
//   clear    : the bus answered (ack or err) this cycle
//   expire   : this is the TIMEOUT-th consecutive unanswered granted cycle
// TIMEOUT = 0 disables the watchdog.
module pu_or1k_bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic expire
);

    localparam logic [16:0] LIMIT = 17'(TIMEOUT);

    logic [15:0] cnt_q;
    logic [16:0] cnt_inc;

    // cnt_q counts earlier unanswered cycles, so cnt_inc includes the current
    // one; the extra bit keeps TIMEOUT = 65535 reachable without wrap.
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    assign expire  = (LIMIT != 17'd0) && active && !clear && (cnt_inc == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clear || !active)
            cnt_q <= '0;
        else
            cnt_q <= cnt_inc[15:0];
    end

endmodule

// File: rtl/pu_or1k_bus_arbiter.sv
// pu_or1k_bus_arbiter -- two-port (fetch / load-store) arbiter onto one
// Wishbone bus. Registered grant; one forced IDLE cycle after each release.
//   clk, rst : clock, synchronous active-high reset
//   bif      : pu_or1k_bus_arbiter_if.slave (ibus_*, dbus_*, bus_* bundles)
// Parameters: ROUND_ROBIN (1 = alternate on contention, 0 = dbus wins),
//             TIMEOUT (watchdog limit in cycles, 0 = off).
module pu_or1k_bus_arbiter
    import pu_or1k_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic                   clk,
    input logic                   rst,
    pu_or1k_bus_arbiter_if.slave  bif
);

    arb_state_e state_q, state_d;
    port_id_t   last_q, last_d;
    logic       wd_active, wd_clear, expire;

    assign wd_active = (state_q != ST_IDLE) && !rst;
    assign wd_clear  = bif.bus_ack_i || bif.bus_err_i;

    pu_or1k_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .active (wd_active),
        .clear  (wd_clear),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        bif.bus_req_o   = 1'b0;
        bif.bus_we_o    = 1'b0;
        bif.bus_burst_o = 1'b0;
        bif.bus_adr_o   = '0;
        bif.bus_dat_o   = '0;
        bif.bus_bsel_o  = '0;
        bif.ibus_ack_o  = 1'b0;
        bif.ibus_err_o  = 1'b0;
        bif.dbus_ack_o  = 1'b0;
        bif.dbus_err_o  = 1'b0;
        bif.ibus_dat_o  = bif.bus_dat_i;
        bif.dbus_dat_o  = bif.bus_dat_i;

        unique case (state_q)
            ST_IDLE: begin
                if (bif.ibus_req_i && bif.dbus_req_i) begin
                    // Contention: fixed mode favours dbus; round-robin
                    // picks whichever port did not win last time.
                    if (!ROUND_ROBIN || last_q == PORT_I) begin
                        state_d = ST_GNT_D;
                        last_d  = PORT_D;
                    end else begin
                        state_d = ST_GNT_I;
                        last_d  = PORT_I;
                    end
                end else if (bif.dbus_req_i) begin
                    state_d = ST_GNT_D;
                    last_d  = PORT_D;
                end else if (bif.ibus_req_i) begin
                    state_d = ST_GNT_I;
                    last_d  = PORT_I;
                end
            end
            ST_GNT_I: begin
                bif.bus_req_o   = bif.ibus_req_i && !expire;
                bif.bus_burst_o = bif.ibus_burst_i;
                bif.bus_adr_o   = bif.ibus_adr_i;
                bif.bus_bsel_o  = 4'hF;
                bif.ibus_ack_o  = bif.bus_ack_i;
                bif.ibus_err_o  = bif.bus_err_i || expire;
                if (!bif.ibus_req_i || bif.bus_err_i || expire ||
                    (bif.bus_ack_i && !bif.ibus_burst_i))
                    state_d = ST_IDLE;
            end
            ST_GNT_D: begin
                bif.bus_req_o   = bif.dbus_req_i && !expire;
                bif.bus_we_o    = bif.dbus_we_i;
                bif.bus_burst_o = bif.dbus_burst_i;
                bif.bus_adr_o   = bif.dbus_adr_i;
                bif.bus_dat_o   = bif.dbus_dat_i;
                bif.bus_bsel_o  = bif.dbus_bsel_i;
                bif.dbus_ack_o  = bif.bus_ack_i;
                bif.dbus_err_o  = bif.bus_err_i || expire;
                if (!bif.dbus_req_i || bif.bus_err_i || expire ||
                    (bif.bus_ack_i && !bif.dbus_burst_i))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing leaves the block while reset is held, even mid-burst.
        if (rst) begin
            bif.bus_req_o   = 1'b0;
            bif.bus_we_o    = 1'b0;
            bif.bus_burst_o = 1'b0;
            bif.bus_adr_o   = '0;
            bif.bus_dat_o   = '0;
            bif.bus_bsel_o  = '0;
            bif.ibus_ack_o  = 1'b0;
            bif.ibus_err_o  = 1'b0;
            bif.dbus_ack_o  = 1'b0;
            bif.dbus_err_o  = 1'b0;
            bif.ibus_dat_o  = '0;
            bif.dbus_dat_o  = '0;
        end
    end

endmodule
